// File: rtl/flex_gearbox_if.sv
// Stream bus for flex_gearbox: input word side, output word side, slip request and status.
// slave = gearbox side, master = the agent driving/consuming the streams.
interface flex_gearbox_if #(
  parameter int unsigned INPUT_WIDTH  = 66,
  parameter int unsigned OUTPUT_WIDTH = 32
);
  localparam int unsigned BUF_WIDTH = INPUT_WIDTH + OUTPUT_WIDTH;
  localparam int unsigned LVL_W     = $clog2(BUF_WIDTH + 1);

  logic [INPUT_WIDTH-1:0]  i_data;
  logic                    i_valid;
  logic                    o_ready;
  logic [OUTPUT_WIDTH-1:0] o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic                    i_slip;
  logic [LVL_W-1:0]        o_level;
  logic                    o_overflow;

  modport master (
    output i_data, i_valid, i_ready, i_slip,
    input  o_ready, o_data, o_valid, o_level, o_overflow
  );

  modport slave (
    input  i_data, i_valid, i_ready, i_slip,
    output o_ready, o_data, o_valid, o_level, o_overflow
  );
endinterface

// File: rtl/flex_gearbox.sv
// Bit-exact INPUT_WIDTH -> OUTPUT_WIDTH gearbox built on an accumulating bit buffer.
// Optional single-bit RX slip is compiled in with `define FLEX_GEARBOX_SLIP_EN.
module flex_gearbox #(
  parameter int unsigned INPUT_WIDTH  = 66,
  parameter int unsigned OUTPUT_WIDTH = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_init_done,
  flex_gearbox_if.slave   bus
);
  localparam int unsigned BUF_WIDTH = INPUT_WIDTH + OUTPUT_WIDTH;
  localparam int unsigned LVL_W     = $clog2(BUF_WIDTH + 1);
  localparam int unsigned EXT_W     = LVL_W + 1;

  localparam logic [EXT_W-1:0] OUT_STEP = EXT_W'(OUTPUT_WIDTH);
  localparam logic [EXT_W-1:0] IN_STEP  = EXT_W'(INPUT_WIDTH);
  localparam logic [EXT_W-1:0] BUF_LIM  = EXT_W'(BUF_WIDTH);

  logic [BUF_WIDTH-1:0] sr_q, sr_d;
  logic [LVL_W-1:0]     lvl_q, lvl_d;
  logic                 ovf_q, ovf_d;

  logic                 slip_pend;
  logic                 slip_exec;

  logic [EXT_W-1:0]     lvl_ext;
  logic [EXT_W-1:0]     lvl_post;
  logic [EXT_W-1:0]     lvl_fill;
  logic [BUF_WIDTH-1:0] sr_shift;
  logic [BUF_WIDTH-1:0] sr_ins;
  logic                 valid_c;
  logic                 ready_c;
  logic                 out_xfer;
  logic                 in_xfer;

`ifdef FLEX_GEARBOX_SLIP_EN
  logic slip_pend_q, slip_pend_d;

  // A slip waits for at least one buffered bit; requests while pending are absorbed.
  assign slip_pend   = slip_pend_q;
  assign slip_exec   = slip_pend_q && (lvl_q != '0);
  assign slip_pend_d = slip_exec ? 1'b0 : (slip_pend_q | bus.i_slip);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slip_pend_q <= 1'b0;
    end else if (!i_init_done) begin
      slip_pend_q <= 1'b0;
    end else begin
      slip_pend_q <= slip_pend_d;
    end
  end
`else
  logic unused_slip;

  assign slip_pend   = 1'b0;
  assign slip_exec   = 1'b0;
  assign unused_slip = bus.i_slip;
`endif

  // Drain/slip shift first, then append the accepted word at the post-shift level.
  always_comb begin
    lvl_ext  = EXT_W'(lvl_q);
    valid_c  = (lvl_ext >= OUT_STEP) && !slip_pend;
    out_xfer = valid_c && bus.i_ready;
    lvl_post = lvl_ext;
    sr_shift = sr_q;
    if (out_xfer) begin
      lvl_post = lvl_ext - OUT_STEP;
      sr_shift = sr_q >> OUTPUT_WIDTH;
    end else if (slip_exec) begin
      lvl_post = lvl_ext - EXT_W'(1);
      sr_shift = sr_q >> 1;
    end
    lvl_fill = lvl_post + IN_STEP;
    ready_c  = (lvl_fill <= BUF_LIM);
    in_xfer  = bus.i_valid && ready_c;
    // Bits above the level are always zero, so OR-ing the word in is an insert.
    sr_ins   = BUF_WIDTH'(bus.i_data) << lvl_post;
    sr_d     = in_xfer ? (sr_shift | sr_ins) : sr_shift;
    lvl_d    = in_xfer ? LVL_W'(lvl_fill) : LVL_W'(lvl_post);
    ovf_d    = ovf_q | (bus.i_valid && !ready_c);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sr_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else if (!i_init_done) begin
      sr_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.o_data     = sr_q[OUTPUT_WIDTH-1:0];
  assign bus.o_valid    = valid_c;
  assign bus.o_ready    = ready_c;
  assign bus.o_level    = lvl_q;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_flex_gearbox.sv
// Randomised bench for flex_gearbox: three instances (66->32, 32->66, 32->32) checked
// every cycle against a bit-FIFO model of the stream.
module tb_flex_gearbox;
`ifdef FLEX_GEARBOX_SLIP_EN
  localparam bit SLIP_ON = 1'b1;
`else
  localparam bit SLIP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;

  always #5 clk = ~clk;

  flex_gearbox_if #(.INPUT_WIDTH(66), .OUTPUT_WIDTH(32)) bus0 ();
  flex_gearbox_if #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(66)) bus1 ();
  flex_gearbox_if #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(32)) bus2 ();

  flex_gearbox #(.INPUT_WIDTH(66), .OUTPUT_WIDTH(32)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_init_done(init_done), .bus(bus0.slave));
  flex_gearbox #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(66)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_init_done(init_done), .bus(bus1.slave));
  flex_gearbox #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(32)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_init_done(init_done), .bus(bus2.slave));

  // Per-instance drive and sample views, widened to 66 bits.
  logic [65:0] din  [3];
  logic        vin  [3];
  logic        rin  [3];
  logic        sin  [3];
  logic [65:0] dout [3];
  logic        vout [3];
  logic        rout [3];
  logic        fout [3];
  logic [7:0]  lout [3];

  assign bus0.i_data  = din[0];
  assign bus1.i_data  = din[1][31:0];
  assign bus2.i_data  = din[2][31:0];
  assign bus0.i_valid = vin[0];
  assign bus1.i_valid = vin[1];
  assign bus2.i_valid = vin[2];
  assign bus0.i_ready = rin[0];
  assign bus1.i_ready = rin[1];
  assign bus2.i_ready = rin[2];
  assign bus0.i_slip  = sin[0];
  assign bus1.i_slip  = sin[1];
  assign bus2.i_slip  = sin[2];

  assign dout[0] = 66'(bus0.o_data);
  assign dout[1] = 66'(bus1.o_data);
  assign dout[2] = 66'(bus2.o_data);
  assign vout[0] = bus0.o_valid;
  assign vout[1] = bus1.o_valid;
  assign vout[2] = bus2.o_valid;
  assign rout[0] = bus0.o_ready;
  assign rout[1] = bus1.o_ready;
  assign rout[2] = bus2.o_ready;
  assign fout[0] = bus0.o_overflow;
  assign fout[1] = bus1.o_overflow;
  assign fout[2] = bus2.o_overflow;
  assign lout[0] = 8'(bus0.o_level);
  assign lout[1] = 8'(bus1.o_level);
  assign lout[2] = 8'(bus2.o_level);

  // Model: the buffer is a window [rd, wr) into an endless bit stream.
  bit mbits [3][4096];
  int wr    [3];
  int rd    [3];
  bit pend  [3];
  bit movf  [3];
  int n_out [3];
  int n_in  [3];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int iw(input int k);
    return (k == 0) ? 66 : 32;
  endfunction

  function automatic int ow(input int k);
    return (k == 1) ? 66 : 32;
  endfunction

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [65:0] exp_word(input int k);
    logic [65:0] w;
    w = '0;
    for (int i = 0; i < ow(k); i++)
      if (rd[k] + i < wr[k]) w[i] = mbits[k][(rd[k] + i) % 4096];
    return w;
  endfunction

  task automatic flush_model(input int k);
    rd[k]   = wr[k];
    pend[k] = 1'b0;
    movf[k] = 1'b0;
  endtask

  // Check current outputs, then advance the model across the coming edge.
  task automatic model_step(input int k);
    int L, L2, o;
    bit ev, sx, drain, rdy;
    o  = ow(k);
    L  = wr[k] - rd[k];
    ev = (L >= o) && !pend[k];
    check_eq($sformatf("i%0d.o_valid", k), 66'(vout[k]), 66'(ev));
    check_eq($sformatf("i%0d.o_data", k), dout[k], exp_word(k));
    check_eq($sformatf("i%0d.o_level", k), 66'(lout[k]), 66'(L));
    check_eq($sformatf("i%0d.o_overflow", k), 66'(fout[k]), 66'(movf[k]));
    sx    = SLIP_ON && pend[k] && (L >= 1);
    drain = ev && rin[k];
    L2    = L - (drain ? o : 0) - (sx ? 1 : 0);
    rdy   = (L2 + iw(k)) <= (iw(k) + o);
    check_eq($sformatf("i%0d.o_ready", k), 66'(rout[k]), 66'(rdy));
    if (vout[k] && rin[k]) n_out[k]++;
    if (rout[k] && vin[k]) n_in[k]++;
    if (!init_done) begin
      flush_model(k);
      return;
    end
    if (drain) rd[k] += o;
    if (sx)    rd[k] += 1;
    if (vin[k]) begin
      if (rdy) begin
        for (int i = 0; i < iw(k); i++) mbits[k][(wr[k] + i) % 4096] = din[k][i];
        wr[k] += iw(k);
      end else begin
        movf[k] = 1'b1;
      end
    end
    if (SLIP_ON) begin
      if (sx)          pend[k] = 1'b0;
      else if (sin[k]) pend[k] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s.i%0d.o_data", tag, k), dout[k], 66'd0);
      check_eq($sformatf("%s.i%0d.o_valid", tag, k), 66'(vout[k]), 66'd0);
      check_eq($sformatf("%s.i%0d.o_level", tag, k), 66'(lout[k]), 66'd0);
      check_eq($sformatf("%s.i%0d.o_overflow", tag, k), 66'(fout[k]), 66'd0);
      check_eq($sformatf("%s.i%0d.o_ready", tag, k), 66'(rout[k]), 66'd1);
    end
  endtask

  // Asynchronous reset pulsed between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_reset_outputs(tag);
    for (int k = 0; k < 3; k++) flush_model(k);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [65:0] rnd66();
    return 66'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    int  slip_cyc;
    int  stall;
    bit  done;
    int  exp_out2;

    rst_n     = 1'b0;
    init_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0; vin[k] = 1'b0; rin[k] = 1'b0; sin[k] = 1'b0;
      wr[k] = 0; rd[k] = 0; pend[k] = 1'b0; movf[k] = 1'b0;
      n_out[k] = 0; n_in[k] = 0;
    end
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate directed run: 16x66 -> 33x32, 33x32 -> 16x66, 12x32 with a double slip request.
    slip_cyc = 0;
    done     = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      for (int k = 0; k < 3; k++) rin[k] = 1'b1;
      vin[0] = (n_in[0] < 16);
      din[0] = rnd66();
      vin[1] = (n_in[1] < 33);
      din[1] = 66'h0_A5C3_0F96;
      vin[2] = (n_in[2] < 12);
      din[2] = 66'(n_in[2] + 1);
      sin[2] = 1'b0;
      if (n_in[2] >= 4 && slip_cyc < 2) begin
        sin[2] = 1'b1;
        slip_cyc++;
      end
      tick();
      done = (n_in[0] >= 16) && (n_in[1] >= 33) && (n_in[2] >= 12);
      for (int k = 0; k < 3; k++) done = done && ((wr[k] - rd[k]) < ow(k));
    end
    check_eq("directed.finished", 66'(done), 66'd1);
    exp_out2 = SLIP_ON ? 11 : 12;
    check_eq("directed.i0.words_out", 66'(n_out[0]), 66'd33);
    check_eq("directed.i1.words_out", 66'(n_out[1]), 66'd16);
    check_eq("directed.i2.words_out", 66'(n_out[2]), 66'(exp_out2));

    // Six-cycle backpressure with input still offered: level saturates, overflow sets.
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 3; k++) begin
        rin[k] = 1'b0; vin[k] = 1'b1; sin[k] = 1'b0;
        din[k] = rnd66();
      end
      tick();
    end
    check_eq("stall.i0.o_overflow", 66'(fout[0]), 66'd1);
    check_eq("stall.i0.o_ready", 66'(rout[0]), 66'd0);

    // init_done low clears everything on the next edge.
    init_done = 1'b0;
    tick();
    init_done = 1'b1;
    check_reset_outputs("init_done");

    // Random traffic with stall bursts and periodic slip pulses.
    stall = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) begin
        vin[k] = ($urandom_range(0, 3) != 0);
        din[k] = rnd66();
        sin[k] = (c % 10 == 0);
      end
      if (stall > 0) begin
        stall--;
        for (int k = 0; k < 3; k++) rin[k] = 1'b0;
      end else begin
        if ($urandom_range(0, 19) == 0) stall = 6;
        for (int k = 0; k < 3; k++) rin[k] = ($urandom_range(0, 3) != 0);
      end
      if (c == 700) init_done = 1'b0;
      if (c == 701) init_done = 1'b1;
      if (c == 1100) async_reset("midstream");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
